multicycle_control: RTL and testbench
=====================================

# multicycle_control

Finite-state control unit for the multicycle RV64 datapath, the sequential successor to the single-cycle main/ALU control pair. Each instruction (R-type add/sub/and/or, optional addi, ld, sd, beq) walks through a Moore state machine. Every state drives the datapath strobes, mux selects and the 4-bit ALU Operation code. Memory states stall on a ready handshake, and a parametrised counter records retired instructions.

## Interface

- `OPW`, default 7: opcode width.
- `FW`, default 4: Funct width, packed as {funct7[5], funct3}.
- `OPERW`, default 4: ALU Operation width.
- `CNTW`, default 32: retired-instruction counter width.
- `EN_ADDI`, default 1: when 1, decode I-type ALU opcode 0010011 with funct3=000 as addi; when 0, treat it as illegal.
- `clk` in 1: clock, all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `Opcode` in OPW: instruction[6:0] from the instruction register.
- `Funct` in FW: {instr[30], instr[14:12]}.
- `mem_ready` in 1: memory completes the current access this cycle.
- `ir_write`, `pc_write`, `pc_write_cond`, `mem_read`, `mem_write`, `reg_write`, `mem_to_reg`, `iord`, `pc_source` out 1 each: datapath strobes and selects.
- `alu_src_a` out 1: 0 selects PC, 1 selects rs1.
- `alu_src_b` out 2: 00 rs2, 01 constant 4, 10 immediate.
- `Operation` out OPERW: ALU code. 0010 add, 0110 sub, 0000 and, 0001 or.
- `state` out 4: current state encoding, for debug.
- `illegal` out 1: one-cycle pulse on an undecodable instruction.
- `retired` out CNTW: count of completed instructions.

## Operation

- States, with their encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ILLEGAL=9. Encodings 10-15 are unreachable; if entered, go to FETCH.
- Opcode and Funct are latched into internal registers in DECODE. All later states use only the latched values.
- Decode rules:
  - 0110011 is R-type.
  - 0010011 is addi, only when EN_ADDI=1 and funct3=000.
  - 0000011 is ld.
  - 0100011 is sd.
  - 1100011 is beq.
  - Every other opcode is illegal.
- R-type Funct mapping: 0000 gives add, 1000 gives sub, 0111 gives and, 0110 gives or. Any other Funct is illegal.
- Transitions:
  - FETCH to DECODE when mem_ready=1; otherwise hold in FETCH.
  - DECODE: ld or sd to MEMADR; R-type or addi to EXEC; beq to BRANCH; illegal to ILLEGAL.
  - MEMADR: ld to MEMRD, sd to MEMWR.
  - MEMRD to MEMWB when mem_ready=1; otherwise hold. MEMWB to FETCH.
  - MEMWR to FETCH when mem_ready=1; otherwise hold.
  - EXEC to ALUWB. ALUWB to FETCH.
  - BRANCH to FETCH. ILLEGAL to FETCH.
- Outputs are Moore (functions of state and latched fields only). Signals not listed for a state are 0.
  - FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, Operation=add. ir_write=1 and pc_write=1 only in the cycle where mem_ready=1; this is the sole Mealy exception.
  - DECODE: alu_src_a=0, alu_src_b=10, Operation=add (branch target precompute).
  - MEMADR: alu_src_a=1, alu_src_b=10, Operation=add.
  - MEMRD: mem_read=1, iord=1.
  - MEMWB: reg_write=1, mem_to_reg=1.
  - MEMWR: mem_write=1, iord=1.
  - EXEC: alu_src_a=1. alu_src_b=00 for R-type, 10 for addi. Operation is decoded from Funct for R-type and is add for addi.
  - ALUWB: reg_write=1, mem_to_reg=0.
  - BRANCH: alu_src_a=1, alu_src_b=00, Operation=sub, pc_write_cond=1, pc_source=1.
  - ILLEGAL: illegal=1.
- retired increments by 1 on the clock edge leaving MEMWB, ALUWB, BRANCH, or MEMWR with mem_ready=1. It wraps modulo 2^CNTW. ILLEGAL does not increment it.

## Timing

- Reset (rst_n=0, asynchronous):
  - State goes to FETCH immediately. retired=0, latched fields=0, illegal=0.
  - Outputs take their FETCH values, with ir_write=0 and pc_write=0 unless mem_ready=1.
- Reset release takes effect on the first rising edge with rst_n=1.
- Latency with mem_ready held at 1: R-type and addi 4 cycles, ld 5, sd 4, beq 3, illegal 3.
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle. Outputs stay constant while stalled.
- Reset asserted mid-instruction aborts it: no retire, no write strobe after the asserting edge.
- Opcode or Funct changing after DECODE has no effect on the instruction in flight.

## Test plan

- Reset, then mem_ready=1 with Opcode=0110011 and Funct=0000, 1000, 0111, 0110 in turn → EXEC shows Operation 0010, 0110, 0000, 0001 respectively; ALUWB reg_write=1; retired ends at 4; each instruction takes 4 cycles.
- ld (0000011) with mem_ready low for 3 cycles in MEMRD → state stays at 3 for 3 extra cycles with mem_read=1 and iord=1; then MEMWB with reg_write=1 and mem_to_reg=1; total 8 cycles.
- sd (0100011), then beq (1100011) → MEMWR mem_write=1; BRANCH shows Operation=0110 and pc_write_cond=1; retired increases by 2.
- Opcode=1111111, then R-type with Funct=0011 → illegal pulses 1 cycle for each; state sequence 0, 1, 9, 0; retired unchanged.
- EN_ADDI=0 build with Opcode 0010011 → ILLEGAL. EN_ADDI=1 build → EXEC with alu_src_b=10, Operation=0010.
- CNTW=3 build: 8 R-type instructions → retired wraps from 7 to 0. Separately, rst_n asserted in MEMRD → state=0 and retired=0 immediately.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control: Moore control FSM for the multicycle RV64 datapath.
// Strobes are registered from the next state; only ir_write/pc_write follow mem_ready in FETCH.
module multicycle_control #(
  parameter int OPW     = 7,
  parameter int FW      = 4,
  parameter int OPERW   = 4,
  parameter int CNTW    = 32,
  parameter bit EN_ADDI = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPW-1:0]   Opcode,
  input  logic [FW-1:0]    Funct,
  input  logic             mem_ready,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             iord,
  output logic             pc_source,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [OPERW-1:0] Operation,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNTW-1:0]  retired
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
    MEMWR = 4'd5, EXEC = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8, ILLEGAL = 4'd9
  } state_e;
  typedef enum logic [2:0] {K_R, K_ADDI, K_LD, K_SD, K_BEQ, K_BAD} kind_e;
  localparam logic [OPERW-1:0] OP_ADD = OPERW'(4'b0010);
  localparam logic [OPERW-1:0] OP_SUB = OPERW'(4'b0110);
  localparam logic [OPERW-1:0] OP_AND = OPERW'(4'b0000);
  localparam logic [OPERW-1:0] OP_OR  = OPERW'(4'b0001);
  localparam int CW = 11 + OPERW;
  localparam logic [CW-1:0] CTL_RST = {8'b0100_0000, 2'b01, OP_ADD, 1'b0};
  state_e          state_q, state_d;
  logic [OPW-1:0]  op_q, op_d;
  logic [FW-1:0]   fn_q, fn_d;
  kind_e           kind;
  logic [OPERW-1:0] r_op;
  logic [CW-1:0]   ctl_q, ctl_d;
  logic [CNTW-1:0] retired_q;
  logic            retire;
  always_comb begin
    op_d = state_q == DECODE ? Opcode : op_q;
    fn_d = state_q == DECODE ? Funct : fn_q;
    kind = op_d == OPW'(7'b0110011)
             ? (fn_d inside {FW'(4'b0000), FW'(4'b1000), FW'(4'b0111), FW'(4'b0110)} ? K_R : K_BAD)
         : op_d == OPW'(7'b0010011) ? (EN_ADDI && fn_d[2:0] == 3'b000 ? K_ADDI : K_BAD)
         : op_d == OPW'(7'b0000011) ? K_LD
         : op_d == OPW'(7'b0100011) ? K_SD
         : op_d == OPW'(7'b1100011) ? K_BEQ : K_BAD;
    r_op = fn_d == FW'(4'b1000) ? OP_SUB
         : fn_d == FW'(4'b0111) ? OP_AND
         : fn_d == FW'(4'b0110) ? OP_OR : OP_ADD;
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = mem_ready ? DECODE : FETCH;
      DECODE: state_d = kind inside {K_LD, K_SD} ? MEMADR
                      : kind inside {K_R, K_ADDI} ? EXEC
                      : kind == K_BEQ ? BRANCH : ILLEGAL;
      MEMADR: state_d = kind == K_SD ? MEMWR : MEMRD;
      MEMRD:  state_d = mem_ready ? MEMWB : MEMRD;
      MEMWR:  state_d = mem_ready ? FETCH : MEMWR;
      EXEC:   state_d = ALUWB;
      default: state_d = FETCH;
    endcase
    retire = state_q inside {MEMWB, ALUWB, BRANCH} || (state_q == MEMWR && mem_ready);
    // Outputs of the state being entered, so the registered strobes line up with state_q
    ctl_d = {
      state_d == BRANCH,
      state_d inside {FETCH, MEMRD},
      state_d == MEMWR,
      state_d inside {MEMWB, ALUWB},
      state_d == MEMWB,
      state_d inside {MEMRD, MEMWR},
      state_d == BRANCH,
      state_d inside {MEMADR, EXEC, BRANCH},
      state_d == FETCH ? 2'b01
        : (state_d inside {DECODE, MEMADR} || (state_d == EXEC && kind == K_ADDI)) ? 2'b10 : 2'b00,
      state_d inside {FETCH, DECODE, MEMADR} ? OP_ADD
        : state_d == BRANCH ? OP_SUB
        : state_d == EXEC ? (kind == K_ADDI ? OP_ADD : r_op) : OP_AND,
      state_d == ILLEGAL
    };
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      op_q      <= '0;
      fn_q      <= '0;
      ctl_q     <= CTL_RST;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      fn_q      <= fn_d;
      ctl_q     <= ctl_d;
      retired_q <= retired_q + CNTW'(retire);
    end
  end
  assign {pc_write_cond, mem_read, mem_write, reg_write, mem_to_reg, iord, pc_source,
          alu_src_a, alu_src_b, Operation, illegal} = ctl_q;
  assign ir_write = state_q == FETCH && mem_ready;
  assign pc_write = state_q == FETCH && mem_ready;
  assign state    = state_q;
  assign retired  = retired_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed + randomized instruction streams checked against a per-instruction trace model.
module tb_multicycle_control;
  localparam int K_R = 0, K_ADDI = 1, K_LD = 2, K_SD = 3, K_BEQ = 4, K_BAD = 5;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
  localparam logic [6:0] OP_SD = 7'b0100011, OP_BEQ = 7'b1100011;
  logic clk = 0, rst_n = 1, mr = 0;
  logic [6:0] opc = 0;
  logic [3:0] fnc = 0;
  logic [2:0] irw, pcw, pwc, mrd, mwr, rgw, m2r, iod, psrc, asa, ill;
  logic [1:0] asb [3];
  logic [3:0] opn [3];
  logic [3:0] stw [3];
  logic [31:0] ret0, ret1;
  logic [2:0] ret2;
  logic [1:0] sel = 0;
  logic [20:0] obs;
  logic [31:0] obs_ret;
  int checks = 0, errors = 0, ret_model = 0, cnt_mask = -1;
  bit en_addi = 1;

  always #5 clk = ~clk;

  multicycle_control u0 (.clk(clk), .rst_n(rst_n), .Opcode(opc), .Funct(fnc), .mem_ready(mr),
    .ir_write(irw[0]), .pc_write(pcw[0]), .pc_write_cond(pwc[0]), .mem_read(mrd[0]),
    .mem_write(mwr[0]), .reg_write(rgw[0]), .mem_to_reg(m2r[0]), .iord(iod[0]),
    .pc_source(psrc[0]), .alu_src_a(asa[0]), .alu_src_b(asb[0]), .Operation(opn[0]),
    .state(stw[0]), .illegal(ill[0]), .retired(ret0));
  multicycle_control #(.EN_ADDI(1'b0)) u1 (.clk(clk), .rst_n(rst_n), .Opcode(opc), .Funct(fnc),
    .mem_ready(mr), .ir_write(irw[1]), .pc_write(pcw[1]), .pc_write_cond(pwc[1]),
    .mem_read(mrd[1]), .mem_write(mwr[1]), .reg_write(rgw[1]), .mem_to_reg(m2r[1]),
    .iord(iod[1]), .pc_source(psrc[1]), .alu_src_a(asa[1]), .alu_src_b(asb[1]),
    .Operation(opn[1]), .state(stw[1]), .illegal(ill[1]), .retired(ret1));
  multicycle_control #(.CNTW(3)) u2 (.clk(clk), .rst_n(rst_n), .Opcode(opc), .Funct(fnc),
    .mem_ready(mr), .ir_write(irw[2]), .pc_write(pcw[2]), .pc_write_cond(pwc[2]),
    .mem_read(mrd[2]), .mem_write(mwr[2]), .reg_write(rgw[2]), .mem_to_reg(m2r[2]),
    .iord(iod[2]), .pc_source(psrc[2]), .alu_src_a(asa[2]), .alu_src_b(asb[2]),
    .Operation(opn[2]), .state(stw[2]), .illegal(ill[2]), .retired(ret2));

  always_comb begin
    obs = {stw[sel], irw[sel], pcw[sel], pwc[sel], mrd[sel], mwr[sel], rgw[sel], m2r[sel],
           iod[sel], psrc[sel], asa[sel], asb[sel], opn[sel], ill[sel]};
    obs_ret = sel == 2'd0 ? ret0 : sel == 2'd1 ? ret1 : {29'd0, ret2};
  end

  function automatic int kind_of(logic [6:0] op, logic [3:0] fn, bit ea);
    if (op == OP_R) return (fn == 4'b0000 || fn == 4'b1000 || fn == 4'b0111 || fn == 4'b0110) ? K_R : K_BAD;
    if (op == OP_I) return (ea && fn[2:0] == 3'b000) ? K_ADDI : K_BAD;
    if (op == OP_LD) return K_LD;
    if (op == OP_SD) return K_SD;
    if (op == OP_BEQ) return K_BEQ;
    return K_BAD;
  endfunction

  function automatic logic [3:0] r_op(logic [3:0] fn);
    case (fn)
      4'b1000: return 4'b0110;
      4'b0111: return 4'b0000;
      4'b0110: return 4'b0001;
      default: return 4'b0010;
    endcase
  endfunction

  // Expected strobes from the state table: {state, ir_write, pc_write, pc_write_cond, mem_read,
  // mem_write, reg_write, mem_to_reg, iord, pc_source, alu_src_a, alu_src_b, Operation, illegal}
  function automatic logic [20:0] exp_ctl(int st, int kind, logic [3:0] fn, logic m);
    logic ir_e, pcw_e, pwc_e, rd_e, wr_e, rw_e, m2r_e, io_e, ps_e, a_e, il_e;
    logic [1:0] b_e;
    logic [3:0] op_e;
    {ir_e, pcw_e, pwc_e, rd_e, wr_e, rw_e, m2r_e, io_e, ps_e, a_e, il_e} = '0;
    b_e = 2'b00;
    op_e = 4'b0000;
    case (st)
      0: begin rd_e = 1; b_e = 2'b01; op_e = 4'b0010; ir_e = m; pcw_e = m; end
      1: begin b_e = 2'b10; op_e = 4'b0010; end
      2: begin a_e = 1; b_e = 2'b10; op_e = 4'b0010; end
      3: begin rd_e = 1; io_e = 1; end
      4: begin rw_e = 1; m2r_e = 1; end
      5: begin wr_e = 1; io_e = 1; end
      6: begin a_e = 1; b_e = kind == K_ADDI ? 2'b10 : 2'b00; op_e = kind == K_ADDI ? 4'b0010 : r_op(fn); end
      7: rw_e = 1;
      8: begin a_e = 1; op_e = 4'b0110; pwc_e = 1; ps_e = 1; end
      default: il_e = 1;
    endcase
    return {4'(st), ir_e, pcw_e, pwc_e, rd_e, wr_e, rw_e, m2r_e, io_e, ps_e, a_e, b_e, op_e, il_e};
  endfunction

  task automatic chk(string tag, logic [20:0] e);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, e);
    end
  endtask

  task automatic chk_ret(string tag);
    checks++;
    assert (obs_ret === 32'(ret_model)) else begin
      errors++;
      $error("FAIL %s: retired got %0d expected %0d", tag, obs_ret, ret_model);
    end
  endtask

  task automatic do_reset(logic [1:0] s, bit ea, int mask);
    @(negedge clk);
    sel = s; en_addi = ea; cnt_mask = mask; rst_n = 0; mr = 0;
    #1 ret_model = 0;
    chk("rst_fetch", exp_ctl(0, K_BAD, 4'b0, 1'b0));
    chk_ret("rst_retired");
    mr = 1;
    #1 chk("rst_fetch_ready", exp_ctl(0, K_BAD, 4'b0, 1'b1));
    @(posedge clk);
    #1 chk("rst_hold", exp_ctl(0, K_BAD, 4'b0, 1'b1));
    @(negedge clk);
    mr = 0; rst_n = 1;
  endtask

  // Builds the expected per-cycle state trace of one instruction, then drives and checks it.
  task automatic run(logic [6:0] op, logic [3:0] fn, int sf, int sm, int abort_at);
    int st_q[$];
    bit m_q[$];
    int k;
    k = kind_of(op, fn, en_addi);
    repeat (sf) begin st_q.push_back(0); m_q.push_back(0); end
    st_q.push_back(0); m_q.push_back(1);
    st_q.push_back(1); m_q.push_back(1'($urandom));
    case (k)
      K_R, K_ADDI: begin
        st_q.push_back(6); m_q.push_back(1'($urandom));
        st_q.push_back(7); m_q.push_back(1'($urandom));
      end
      K_LD: begin
        st_q.push_back(2); m_q.push_back(1'($urandom));
        repeat (sm) begin st_q.push_back(3); m_q.push_back(0); end
        st_q.push_back(3); m_q.push_back(1);
        st_q.push_back(4); m_q.push_back(1'($urandom));
      end
      K_SD: begin
        st_q.push_back(2); m_q.push_back(1'($urandom));
        repeat (sm) begin st_q.push_back(5); m_q.push_back(0); end
        st_q.push_back(5); m_q.push_back(1);
      end
      K_BEQ: begin st_q.push_back(8); m_q.push_back(1'($urandom)); end
      default: begin st_q.push_back(9); m_q.push_back(1'($urandom)); end
    endcase
    foreach (st_q[i]) begin
      @(negedge clk);
      mr = m_q[i];
      if (st_q[i] <= 1) begin opc = op; fnc = fn; end
      else begin opc = 7'($urandom); fnc = 4'($urandom); end
      #1 chk($sformatf("cyc%0d_st%0d_op%b_fn%b", i, st_q[i], op, fn), exp_ctl(st_q[i], k, fn, m_q[i]));
      chk_ret($sformatf("retired_cyc%0d_op%b", i, op));
      if (i == abort_at) begin
        #2 rst_n = 0;
        #1 ret_model = 0;
        chk("abort_state", exp_ctl(0, K_BAD, 4'b0, mr));
        chk_ret("abort_retired");
        return;
      end
    end
    if (k != K_BAD) ret_model = (ret_model + 1) & cnt_mask;
  endtask

  task automatic idle_check(string tag);
    @(negedge clk);
    mr = 0;
    #1 chk(tag, exp_ctl(0, K_BAD, 4'b0, 1'b0));
    chk_ret({tag, "_retired"});
  endtask

  initial begin
    logic [6:0] ops [6];
    logic [3:0] rfn [4];
    logic [6:0] op;
    logic [3:0] fn;
    ops = '{OP_R, OP_I, OP_LD, OP_SD, OP_BEQ, 7'h7f};
    rfn = '{4'b0000, 4'b1000, 4'b0111, 4'b0110};
    #2 rst_n = 0;
    do_reset(2'd0, 1'b1, -1);
    foreach (rfn[j]) run(OP_R, rfn[j], 0, 0, -1);
    idle_check("after_4_rtype");
    run(OP_LD, 4'b0011, 0, 3, -1);
    run(OP_SD, 4'b0011, 0, 0, -1);
    run(OP_BEQ, 4'b0000, 0, 0, -1);
    run(7'b1111111, 4'b0000, 0, 0, -1);
    run(OP_R, 4'b0011, 0, 0, -1);
    run(OP_I, 4'b0000, 1, 0, -1);
    run(OP_I, 4'b1000, 0, 0, -1);
    run(OP_I, 4'b0101, 0, 0, -1);
    idle_check("after_directed");
    for (int n = 0; n < 40; n++) begin
      op = ops[$urandom_range(0, 5)];
      if (op == 7'h7f) op = 7'($urandom);
      fn = $urandom_range(0, 3) == 0 ? 4'($urandom) : rfn[$urandom_range(0, 3)];
      run(op, fn, $urandom_range(0, 2), $urandom_range(0, 2), -1);
    end
    idle_check("after_random");
    do_reset(2'd1, 1'b0, -1);
    run(OP_I, 4'b0000, 0, 0, -1);
    run(OP_R, 4'b0110, 0, 0, -1);
    idle_check("no_addi_build");
    do_reset(2'd2, 1'b1, 7);
    for (int n = 0; n < 8; n++) run(OP_R, rfn[n % 4], $urandom_range(0, 1), 0, -1);
    idle_check("cnt3_wrap");
    do_reset(2'd0, 1'b1, -1);
    run(OP_R, 4'b0000, 0, 0, -1);
    run(OP_LD, 4'b0000, 0, 2, 3);
    do_reset(2'd0, 1'b1, -1);
    run(OP_BEQ, 4'b0000, 0, 0, -1);
    idle_check("after_abort");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
